uart_tx: RTL and testbench

//  UART transmitter, counterpart of the 16x-oversampled UART receiver. Serialises a parallel

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx.sv | 130 +++++++++++++
 tb/tb_uart_tx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path.
// State encodings, parity modes and oversampling ratio.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start, DBIT data bits LSB first, optional parity, stop.
// Paced by the shared 16x s_tick; tx pin is registered.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);
  import uart_pkg::*;

  localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  logic [2:0]      state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            p_q, p_d;
  logic            tx_q, tx_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      p_q     <= p_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    p_d     = p_q;
    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          b_d     = din;
          s_d     = '0;
          p_d     = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d = '0;
            p_d = p_q ^ b_q[0];
            b_d = b_q >> 1;
            if (n_q == N_LAST)
              state_d = (PARITY != PAR_NONE)
                      ? uart_pkg::PARITY : STOP;
            else
              n_d = n_q + 3'd1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == STOP_LAST)
            state_d = IDLE;
          else
            s_d = s_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx_d is registered into tx_q so the pin never sees decode glitches
  always_comb begin
    tx_d         = 1'b1;
    tx_done_tick = 1'b0;
    unique case (state_q)
      START: tx_d = 1'b0;
      DATA:  tx_d = b_q[0];
      uart_pkg::PARITY:
        tx_d = (PARITY == PAR_EVEN) ? p_q : ~p_q;
      STOP:
        tx_done_tick = s_tick && (s_q == STOP_LAST);
      default: tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx across parity and stop-length variants.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       tick_en = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  logic [4:0] txv, bsy, dn;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int dcnt [5] = '{default: 0};
  int fc, fc1, fc2, dc, d0;

  localparam logic [15:0] FA5  = 16'b00000_1_10100101_0;
  localparam logic [15:0] F07E = 16'b0000_1_1_00000111_0;
  localparam logic [15:0] F07O = 16'b0000_1_0_00000111_0;
  localparam logic [15:0] F01  = 16'b00000_1_00000001_0;
  localparam logic [15:0] F02  = 16'b00000_1_00000010_0;
  localparam logic [15:0] F3C  = 16'b00000_1_00111100_0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    for (int i = 0; i < 5; i++)
      dcnt[i] <= dcnt[i] + int'(dn[i]);

  initial begin
    int tc;
    tc = 0;
    forever begin
      @(posedge clk);
      #1;
      s_tick = tick_en && (tc == 3);
      tc = (tc + 1) % 4;
    end
  end

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_n (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .tx_start(tx_start), .din(din), .tx(txv[0]),
    .tx_busy(bsy[0]), .tx_done_tick(dn[0]));

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_e (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .tx_start(tx_start), .din(din), .tx(txv[1]),
    .tx_busy(bsy[1]), .tx_done_tick(dn[1]));

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_o (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .tx_start(tx_start), .din(din), .tx(txv[2]),
    .tx_busy(bsy[2]), .tx_done_tick(dn[2]));

  uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u_s32 (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .tx_start(tx_start), .din(din), .tx(txv[3]),
    .tx_busy(bsy[3]), .tx_done_tick(dn[3]));

  uart_tx #(.DBIT(8), .SB_TICK(24), .PARITY(0)) u_s24 (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .tx_start(tx_start), .din(din), .tx(txv[4]),
    .tx_busy(bsy[4]), .tx_done_tick(dn[4]));

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(posedge clk); #1;
    din = d;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bsy != 5'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (bsy != 5'b0) chk("idle_timeout", 32'(bsy), 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_frame(input int idx, input logic [15:0] fr,
                             input int nb, input string tag,
                             output int fall);
    int k = 0;
    fall = -1;
    do begin
      @(negedge clk);
      k++;
    end while (txv[idx] !== 1'b0 && k < 8);
    if (txv[idx] !== 1'b0) begin
      chk({tag, "_nofall"}, 32'(txv[idx]), 0);
      return;
    end
    fall = cyc;
    repeat (32) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      if (i > 0) repeat (64) @(negedge clk);
      chk($sformatf("%s_b%0d", tag, i), 32'(txv[idx]), 32'(fr[i]));
      chk($sformatf("%s_busy%0d", tag, i), 32'(bsy[idx]), 1);
    end
  endtask

  task automatic wait_done(input int idx, output int at);
    int k = 0;
    at = -1;
    do begin
      @(negedge clk);
      k++;
    end while (dn[idx] !== 1'b1 && k < 200);
    chk("done_seen", 32'(dn[idx]), 1);
    at = cyc;
  endtask

  task automatic measure(input int idx, input int sb, input string tag);
    logic prev = 1'b1;
    int r1 = -1, f2 = -1, lr = -1, nf = 0, k = 0;
    logic got = 1'b0;
    while (k < 1500 && !got) begin
      @(negedge clk);
      k++;
      if (prev && !txv[idx]) begin
        nf++;
        if (nf == 2) f2 = cyc;
      end
      if (!prev && txv[idx]) begin
        lr = cyc;
        if (r1 < 0) r1 = cyc;
      end
      if (dn[idx]) got = 1'b1;
      prev = txv[idx];
    end
    chk({tag, "_done"}, 32'(got), 1);
    chk({tag, "_bit"}, f2 - r1, 64);
    // tx rises 1 clk after STOP entry; done flags the last STOP cycle
    chk({tag, "_stop"}, cyc - lr, 4 * sb - 2);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(txv), 32'h1f);
    chk("rst_busy", 32'(bsy), 0);
    chk("rst_done", 32'(dn), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_tx", 32'(txv), 32'h1f);

    d0 = dcnt[0];
    send(8'hA5);
    check_frame(0, FA5, 10, "t1", fc);
    wait_idle();
    chk("t1_done_cnt", dcnt[0] - d0, 1);

    send(8'h07);
    fork
      check_frame(1, F07E, 11, "t2e", fc1);
      check_frame(2, F07O, 11, "t2o", fc2);
    join
    wait_idle();

    d0 = dcnt[0];
    send(8'hA5);
    fork
      check_frame(0, FA5, 10, "t3", fc);
      begin
        repeat (250) @(posedge clk); #1;
        din = 8'hFF;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
      end
    join
    wait_idle();
    repeat (200) @(negedge clk);
    chk("t3_nobusy", 32'(bsy[0]), 0);
    chk("t3_done_cnt", dcnt[0] - d0, 1);

    @(posedge clk); #1;
    din = 8'h01;
    tx_start = 1'b1;
    @(posedge clk); #1;
    din = 8'h02;
    check_frame(0, F01, 10, "t4a", fc);
    wait_done(0, dc);
    @(negedge clk);
    chk("t4_gap_busy", 32'(bsy[0]), 0);
    chk("t4_gap_tx", 32'(txv[0]), 1);
    @(negedge clk);
    chk("t4_start_busy", 32'(bsy[0]), 1);
    chk("t4_start_tx", 32'(txv[0]), 1);
    fork
      check_frame(0, F02, 10, "t4b", fc);
      begin
        repeat (20) @(posedge clk); #1;
        tx_start = 1'b0;
      end
    join
    chk("t4_fall_gap", fc - dc, 3);
    wait_idle();

    send(8'hA5);
    check_frame(0, FA5, 5, "t5a", fc);
    #1;
    reset = 1'b1;
    d0 = dcnt[0];
    #1;
    chk("t5_rst_tx", 32'(txv[0]), 1);
    chk("t5_rst_busy", 32'(bsy[0]), 0);
    chk("t5_rst_done", 32'(dn[0]), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_no_done", dcnt[0] - d0, 0);
    send(8'h3C);
    check_frame(0, F3C, 10, "t5b", fc);
    wait_idle();

    tick_en = 1'b0;
    send(8'h00);
    repeat (300) @(negedge clk);
    chk("t6_hold_tx", 32'(txv[0]), 0);
    chk("t6_hold_busy", 32'(bsy[0]), 1);
    tick_en = 1'b1;
    wait_idle();

    send(8'h55);
    fork
      measure(3, 32, "t7s32");
      measure(4, 24, "t7s24");
      measure(0, 16, "t7s16");
    join
    wait_idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
